// File: rtl/e2prom_rw_checker_if.sv
// Handshake/bus bundle between the EEPROM r/w checker and the I2C byte master
// plus the test control/status lines.
interface e2prom_rw_checker_if;
    logic        run;
    logic        flag_done;
    logic [7:0]  data_read;
    logic        start;
    logic        ctrl_w0_r1;
    logic [15:0] addr;
    logic [7:0]  data_write;
    logic        busy;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] err_addr;
    logic [7:0]  err_data;

    modport master (
        input  run, flag_done, data_read,
        output start, ctrl_w0_r1, addr, data_write,
        output busy, pass, fail, timeout, err_addr, err_data
    );

    modport slave (
        output run, flag_done, data_read,
        input  start, ctrl_w0_r1, addr, data_write,
        input  busy, pass, fail, timeout, err_addr, err_data
    );
endinterface

// File: rtl/e2prom_rw_checker.sv
// Writes addr[7:0]^SEED to BYTE_COUNT consecutive EEPROM addresses through the
// I2C byte master, then reads them back and reports pass/fail/timeout.
module e2prom_rw_checker #(
    parameter int unsigned BYTE_COUNT     = 16,
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter logic [7:0]  SEED           = 8'hA5,
    parameter int unsigned WR_GAP_CYCLES  = 250_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    e2prom_rw_checker_if.master bus
);
    localparam int GW = $clog2(WR_GAP_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [8:0]    LAST_IDX = 9'(BYTE_COUNT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((WR_GAP_CYCLES > 0) ? WR_GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_WR_GAP, S_RD_REQ, S_RD_WAIT, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [8:0]  r_idx;
    logic [GW-1:0] r_gap;
    logic [TW-1:0] r_to;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_rw;
    logic        r_pass, r_fail, r_timeout, r_mis;
    logic [15:0] r_err_addr;
    logic [7:0]  r_err_data;

    logic        w_last, w_gap_hit, w_to_hit, w_bad;
    logic [8:0]  w_idx_nxt;
    logic [15:0] w_addr_nxt;
    logic [7:0]  w_wdata_nxt;

    assign w_last      = (r_idx == LAST_IDX);
    assign w_gap_hit   = (r_gap >= GAP_LAST);
    assign w_to_hit    = (r_to >= TO_LAST);
    assign w_bad       = (bus.data_read != (r_addr[7:0] ^ SEED));
    assign w_idx_nxt   = w_last ? 9'd0 : r_idx + 9'd1;
    assign w_addr_nxt  = BASE_ADDR + {7'd0, w_idx_nxt};
    assign w_wdata_nxt = w_addr_nxt[7:0] ^ SEED;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.run) w_next = S_WR_REQ;
            S_WR_REQ:  w_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bus.flag_done)  w_next = S_WR_GAP;
                else if (w_to_hit)  w_next = S_IDLE;
            end
            S_WR_GAP:  if (w_gap_hit) w_next = w_last ? S_RD_REQ : S_WR_REQ;
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bus.flag_done)  w_next = w_last ? S_DONE : S_RD_REQ;
                else if (w_to_hit)  w_next = S_IDLE;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Bus fields are loaded on the edge that enters a REQ state so they are
    // valid in the start cycle and stay put until the next REQ.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_idx      <= '0;
            r_gap      <= '0;
            r_to       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rw       <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_mis      <= 1'b0;
            r_err_addr <= '0;
            r_err_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_pass     <= 1'b0;
                        r_fail     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_mis      <= 1'b0;
                        r_err_addr <= '0;
                        r_err_data <= '0;
                        r_idx      <= '0;
                        r_addr     <= BASE_ADDR;
                        r_wdata    <= BASE_ADDR[7:0] ^ SEED;
                        r_rw       <= 1'b0;
                    end
                end
                S_WR_REQ, S_RD_REQ: r_to <= TW'(1);
                S_WR_WAIT, S_RD_WAIT: begin
                    if (bus.flag_done) begin
                        r_gap <= '0;
                        if (r_state == S_RD_WAIT) begin
                            if (w_bad) r_mis <= 1'b1;
                            if (w_bad && !r_mis) begin
                                r_err_addr <= r_addr;
                                r_err_data <= bus.data_read;
                            end
                            if (w_last) begin
                                r_pass <= !(r_mis || w_bad);
                                r_fail <= r_mis || w_bad;
                            end else begin
                                r_idx   <= w_idx_nxt;
                                r_addr  <= w_addr_nxt;
                                r_wdata <= w_wdata_nxt;
                            end
                        end
                    end else if (w_to_hit) begin
                        // timeout replaces any mismatch report already latched
                        r_timeout  <= 1'b1;
                        r_fail     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_err_addr <= r_addr;
                        r_err_data <= '0;
                    end else begin
                        r_to <= r_to + TW'(1);
                    end
                end
                S_WR_GAP: begin
                    if (w_gap_hit) begin
                        r_idx   <= w_idx_nxt;
                        r_addr  <= w_addr_nxt;
                        r_wdata <= w_wdata_nxt;
                        r_rw    <= w_last;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start      = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.ctrl_w0_r1 = r_rw;
    assign bus.addr       = r_addr;
    assign bus.data_write = r_wdata;
    assign bus.pass       = r_pass;
    assign bus.fail       = r_fail;
    assign bus.timeout    = r_timeout;
    assign bus.err_addr   = r_err_addr;
    assign bus.err_data   = r_err_data;
endmodule

// File: tb/tb_e2prom_rw_checker.sv
// Random-latency EEPROM/I2C responder around e2prom_rw_checker; expected
// addresses, data, spacing and verdicts come from a transaction-level model.
module tb_e2prom_rw_checker;
    localparam int          N    = 4;
    localparam logic [15:0] BASE = 16'hFFFE;
    localparam logic [7:0]  SEED = 8'hA5;
    localparam int          G    = 8;
    localparam int          TO   = 50;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    e2prom_rw_checker_if bus();

    e2prom_rw_checker #(
        .BYTE_COUNT(N), .BASE_ADDR(BASE), .SEED(SEED),
        .WR_GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ea(input int k);
        return BASE + 16'(k);
    endfunction

    function automatic logic [7:0] ed(input int k);
        logic [15:0] a;
        a = ea(k);
        return a[7:0] ^ SEED;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus.start, bus.ctrl_w0_r1, bus.busy, bus.pass, bus.fail, bus.timeout}, 64'd0);
        chk({tag, "_dat"}, {bus.addr, bus.data_write, bus.err_addr, bus.err_data}, 64'd0);
    endtask

    // cmask: reads to corrupt; hang_k/rst_k: transaction index to stall / reset in (-1 none)
    task automatic run_test(input logic [N-1:0] cmask, input int hang_k, input int rst_k, input bit done_run);
        logic [7:0] mem  [N];
        logic [7:0] cval [N];
        int  k, kcur, nd, cyc, t_start, t_done, lat, first_bad, nst;
        bit  outst, last_wr, fin;
        first_bad = -1;
        for (int j = N - 1; j >= 0; j--) begin
            cval[j] = ed(j) ^ 8'($urandom_range(1, 255));
            mem[j]  = 8'h00;
            if (cmask[j]) first_bad = j;
        end
        repeat (2) @(negedge sys_clk);
        bus.run = 1'b1;
        @(negedge sys_clk);
        bus.run = 1'b0;
        chk("busy_t1", bus.busy, 1);
        chk("start_t1", bus.start, 1);
        k = 0; kcur = 0; nd = 0; cyc = 0; t_start = 0; t_done = -100; lat = 1;
        outst = 0; last_wr = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            bus.flag_done = 1'b0;
            bus.data_read = 8'($urandom);
            bus.run       = (cyc == 6);
            if (nd == 2 * N && cyc == t_done + 1) begin
                chk("pass",     bus.pass,     (first_bad < 0));
                chk("fail",     bus.fail,     (first_bad >= 0));
                chk("timeout",  bus.timeout,  0);
                chk("busy_end", bus.busy,     0);
                chk("err_addr", bus.err_addr, (first_bad >= 0) ? ea(first_bad) : 16'h0);
                chk("err_data", bus.err_data, (first_bad >= 0) ? cval[first_bad] : 8'h0);
                if (done_run) bus.run = 1'b1;
                fin = 1;
            end else if (bus.start) begin
                kcur = k;
                chk("start_outst", outst, 0);
                chk("addr", bus.addr, ea(kcur % N));
                chk("rw", bus.ctrl_w0_r1, (kcur >= N));
                if (kcur < N) chk("wdata", bus.data_write, ed(kcur));
                if (kcur > 0) chk("spacing", cyc - t_done, last_wr ? G + 1 : 1);
                outst = 1; t_start = cyc; k++;
                lat = (kcur == rst_k) ? 10 : $urandom_range(1, 6);
            end else if (outst && kcur == hang_k) begin
                if (!bus.busy) begin
                    chk("to_cycle",    cyc - t_start, TO);
                    chk("to_flags",    {bus.pass, bus.fail, bus.timeout}, 3'b011);
                    chk("to_err_addr", bus.err_addr, ea(kcur % N));
                    chk("to_err_data", bus.err_data, 0);
                    fin = 1;
                end
            end else if (outst && kcur == rst_k && cyc == t_start + 1) begin
                sys_rst = 1'b1;
                @(negedge sys_clk);
                chk_zero("rst_mid");
                sys_rst = 1'b0;
                fin = 1;
            end else if (outst && cyc == t_start + lat) begin
                bus.flag_done = 1'b1;
                if (kcur < N) mem[kcur] = bus.data_write;
                else bus.data_read = cmask[kcur-N] ? cval[kcur-N] : mem[kcur-N];
                outst = 0; t_done = cyc; last_wr = (kcur < N); nd++;
            end else if (!outst && last_wr && cyc == t_done + 3) begin
                bus.flag_done = 1'b1;
            end
            @(negedge sys_clk);
            cyc++;
        end
        chk("finished", fin, 1);
        bus.run = 1'b0;
        bus.flag_done = 1'b0;
        nst = 0;
        repeat (15) begin
            if (bus.start || bus.busy) nst++;
            @(negedge sys_clk);
        end
        chk("idle_after", nst, 0);
    endtask

    initial begin
        bus.run = 1'b0;
        bus.flag_done = 1'b0;
        bus.data_read = 8'h00;
        repeat (3) @(negedge sys_clk);
        chk_zero("reset");
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_zero("post_reset");

        run_test('0, -1, -1, 1'b0);
        run_test(4'b0100, -1, -1, 1'b1);
        run_test(4'b1010, -1, -1, 1'b0);
        for (int t = 0; t < 6; t++)
            run_test(N'($urandom), -1, -1, 1'($urandom));
        run_test('0, 1, -1, 1'b0);
        run_test(4'b0001, N + 2, -1, 1'b0);
        run_test('0, -1, N + 1, 1'b0);
        run_test('0, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/e2prom_rw_checker.md
# e2prom_rw_checker

Command sequencer that drives the I2C byte-transaction master (`i2c_drive`) from upstream, replacing the fixed controller for board bring-up and production test. On a `run` pulse it writes a deterministic pattern to `BYTE_COUNT` consecutive EEPROM addresses and then reads every byte back. It waits the EEPROM internal write-cycle time after each write and compares each read byte against the expected value. It reports pass/fail, the first failing address and data, and a timeout if the master stops answering.

## Interface
Parameters:
- `BYTE_COUNT`, 16: number of bytes written then verified; range 1..256.
- `BASE_ADDR`, 16'h0000: first EEPROM address; addresses wrap modulo 2^16.
- `SEED`, 8'hA5: pattern byte; expected data = `addr[7:0] ^ SEED`.
- `WR_GAP_CYCLES`, 250_000: idle cycles after each write `flag_done` (5 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles from `start` to `flag_done`.

Ports:
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `run`  in  1  one-cycle request to start a test; ignored while `busy`=1.
- `flag_done`  in  1  one-cycle pulse from the master: transaction complete.
- `data_read`  in  8  read byte from the master; valid in the `flag_done` cycle of a read.
- `start`  out  1  one-cycle pulse to the master to launch a transaction.
- `ctrl_w0_r1`  out  1  0 = write, 1 = read.
- `addr`  out  16  EEPROM byte address.
- `data_write`  out  8  byte to write.
- `busy`  out  1  high from the cycle after an accepted `run` until DONE.
- `pass`  out  1  test finished with no mismatch and no timeout.
- `fail`  out  1  test finished with a mismatch or a timeout.
- `timeout`  out  1  the failure was a timeout.
- `err_addr`  out  16  address of the first mismatch or of the timed-out transaction.
- `err_data`  out  8  byte read at the first mismatch; 0 on timeout.

## Operation
- Reset values:
  - all outputs are 0;
  - state = IDLE.
- States and transitions:
  - **IDLE:** on `run`, clear `pass`/`fail`/`timeout`/`err_*`, set index i=0, go to WR_REQ.
  - **WR_REQ:** drive `addr`=`BASE_ADDR`+i, `data_write`=pattern, `ctrl_w0_r1`=0, pulse `start` for 1 cycle, go to WR_WAIT.
  - **WR_WAIT:** on `flag_done`, go to WR_GAP.
  - **WR_GAP:** count `WR_GAP_CYCLES`, then:
    - if i=`BYTE_COUNT`-1, set i=0 and go to RD_REQ;
    - otherwise i++ and go to WR_REQ.
  - **RD_REQ:** same as WR_REQ but with `ctrl_w0_r1`=1, then go to RD_WAIT.
  - **RD_WAIT:** on `flag_done`, compare `data_read` with the expected byte.
    - On the first mismatch, latch `err_addr`/`err_data` and set the sticky mismatch flag; continue through the remaining addresses.
    - Then: if i=`BYTE_COUNT`-1, go to DONE; otherwise i++ and go to RD_REQ.
  - **DONE:** assert `pass` = !mismatch or `fail` = mismatch (exactly one of them), deassert `busy`, go to IDLE. `pass`/`fail` hold until the next accepted `run` or reset.
- Timeout:
  - A counter runs in WR_WAIT and RD_WAIT and is cleared at every `start`.
  - When it reaches `TIMEOUT_CYCLES` without `flag_done`, set `timeout`=1, `fail`=1, `err_addr`=current `addr`, `err_data`=0, and go to IDLE.
  - A timeout overrides an earlier latched mismatch.
- Output holding:
  - `addr`, `data_write` and `ctrl_w0_r1` are registered.
  - They are held stable from the `start` cycle through the `flag_done` cycle, and keep their last values in IDLE.
- Widths:
  - i is 9 bits.
  - Address arithmetic is 16-bit and wraps: 16'hFFFF+1 = 16'h0000.
  - Counters are sized with `$clog2` of their parameter + 1.

## Timing
- `run` at cycle T:
  - `busy`=1 at T+1;
  - first `start` pulse at T+1, with `addr`/`data_write`/`ctrl_w0_r1` valid in the same cycle.
- Read `start` issue points:
  - the first read `start` is issued exactly `WR_GAP_CYCLES`+1 cycles after the last write `flag_done`;
  - every later read `start` is issued 1 cycle after the previous `flag_done`.
- DONE: `pass`/`fail` become visible 1 cycle after the final read `flag_done`, with `busy`=0 in the same cycle.
- Input handling:
  - `flag_done` outside WR_WAIT/RD_WAIT is ignored.
  - `run` coinciding with DONE is ignored.
  - `sys_rst` mid-test returns to IDLE next edge, with all outputs 0 and no further `start`.
- Throughput: at most one outstanding transaction; `start` is never reissued before `flag_done` or timeout.

## Test plan
- **Pass run:** `BYTE_COUNT`=4, `BASE_ADDR`=16'h0010, `WR_GAP_CYCLES`=8, model echoes writes. `run` → writes to 0x0010..0x0013 with data B5,B4,B7,B6; 4 reads follow; `pass`=1, `fail`=0, `busy`=0.
- **Mismatch:** as above, but the model corrupts address 0x0012 to 8'h00 → `fail`=1, `timeout`=0, `err_addr`=16'h0012, `err_data`=8'h00. All 4 reads are still issued.
- **Timeout:** `TIMEOUT_CYCLES`=50, model never returns `flag_done` on the 2nd write → `fail`=1, `timeout`=1, `err_addr`=`BASE_ADDR`+1 at cycle 50 after that `start`. No further `start`.
- **Wrap:** `BASE_ADDR`=16'hFFFE, `BYTE_COUNT`=3 → addresses FFFE, FFFF, 0000. Expected data uses low byte 00 ^ A5 = A5.
- **Gap and ignore:** check exactly `WR_GAP_CYCLES` idle cycles between each write `flag_done` and the next `start`. `run` pulsed while `busy` has no effect; a spurious `flag_done` in WR_GAP is ignored.
- **Reset mid-read:** assert `sys_rst` during RD_WAIT → all outputs 0 next cycle. A subsequent `run` performs a full clean test ending in `pass`.
